dense_layer_sequencer: RTL and testbench

DENSE_LAYER_SEQUENCER -- requirements
Module: dense_layer_sequencer

---
 rtl/dense_layer_sequencer_if.sv | 40 ++++
 rtl/dense_layer_sequencer.sv | 136 +++++++++++++
 tb/tb_dense_layer_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_layer_sequencer_if.sv
// Handshake and memory-control bundle between the dense-layer sequencer and its
// surroundings: input stream, RAM/ROM addressing, MAC and activation handshakes.
`timescale 1ns/1ps
interface dense_layer_sequencer_if #(
    parameter int IAW = 7,
    parameter int WAW = 10,
    parameter int BAW = 6,
    parameter int RAW = 4
);
    logic           start;
    logic           s_tvalid;
    logic           s_tready;
    logic           in_we;
    logic [IAW-1:0] in_waddr;
    logic [IAW-1:0] in_raddr;
    logic           w_en;
    logic [WAW-1:0] w_addr;
    logic           acc_clear;
    logic           mac_start;
    logic           mac_done;
    logic [BAW-1:0] b_addr;
    logic           act_start;
    logic           act_done;
    logic           res_we;
    logic [RAW-1:0] res_addr;
    logic           busy;
    logic           done;

    modport slave (
        input  start, s_tvalid, mac_done, act_done,
        output s_tready, in_we, in_waddr, in_raddr, w_en, w_addr, acc_clear,
               mac_start, b_addr, act_start, res_we, res_addr, busy, done
    );

    modport master (
        output start, s_tvalid, mac_done, act_done,
        input  s_tready, in_we, in_waddr, in_raddr, w_en, w_addr, acc_clear,
               mac_start, b_addr, act_start, res_we, res_addr, busy, done
    );
endinterface

// File: rtl/dense_layer_sequencer.sv
// Sequences one dense-layer pass: load N_IN inputs, N_OUT x N_IN MAC steps, bias+sigmoid
// and result store per neuron. Optional busy-cycle counter under DENSE_SEQ_PERF_CNT_EN.
`timescale 1ns/1ps
module dense_layer_sequencer #(
    parameter int N_IN  = 64,
    parameter int N_OUT = 10,
    parameter int IAW   = 7,
    parameter int WAW   = 10,
    parameter int BAW   = 6,
    parameter int RAW   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    dense_layer_sequencer_if.slave bus
`ifdef DENSE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]            perf_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE, LOAD, MAC_ISSUE, MAC_WAIT, ACT_ISSUE, ACT_WAIT, STORE, DONE
    } state_t;

    localparam logic [IAW-1:0] LAST_K   = IAW'(N_IN - 1);
    localparam logic [BAW-1:0] LAST_N   = BAW'(N_OUT - 1);
    localparam logic [WAW-1:0] W_STRIDE = WAW'(N_IN);

    state_t         r_state;
    state_t         w_state_next;
    logic [IAW-1:0] r_count;
    logic [IAW-1:0] r_k;
    logic [BAW-1:0] r_n;
    logic [WAW-1:0] r_wbase;
    logic           r_first;

    logic w_beat;
    logic w_last_beat;
    logic w_mac_ack;
    logic w_act_ack;
    logic w_last_k;
    logic w_last_n;

    // A done input arriving in the same cycle as its start pulse belongs to no
    // issued operation, so acknowledges are masked during the first wait cycle.
    assign w_beat      = bus.s_tvalid && (r_state == LOAD);
    assign w_last_beat = w_beat && (r_count == LAST_K);
    assign w_mac_ack   = (r_state == MAC_WAIT) && !r_first && bus.mac_done;
    assign w_act_ack   = (r_state == ACT_WAIT) && !r_first && bus.act_done;
    assign w_last_k    = (r_k == LAST_K);
    assign w_last_n    = (r_n == LAST_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (bus.start) w_state_next = LOAD;
            LOAD:      if (w_last_beat) w_state_next = MAC_ISSUE;
            MAC_ISSUE: w_state_next = MAC_WAIT;
            MAC_WAIT:  if (w_mac_ack) w_state_next = w_last_k ? ACT_ISSUE : MAC_ISSUE;
            ACT_ISSUE: w_state_next = ACT_WAIT;
            ACT_WAIT:  if (w_act_ack) w_state_next = STORE;
            STORE:     w_state_next = w_last_n ? DONE : MAC_ISSUE;
            DONE:      w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    // r_wbase tracks n*N_IN incrementally so the weight address needs no multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_k     <= '0;
            r_n     <= '0;
            r_wbase <= '0;
            r_first <= 1'b0;
        end else begin
            r_first <= (r_state == MAC_ISSUE) || (r_state == ACT_ISSUE);
            if ((r_state == IDLE) && bus.start) begin
                r_count <= '0;
                r_k     <= '0;
                r_n     <= '0;
                r_wbase <= '0;
            end
            if (w_beat) begin
                r_count <= r_count + 1'b1;
            end
            if (w_mac_ack) begin
                r_k <= w_last_k ? '0 : r_k + 1'b1;
            end
            if ((r_state == STORE) && !w_last_n) begin
                r_n     <= r_n + 1'b1;
                r_wbase <= r_wbase + W_STRIDE;
            end
        end
    end

    assign bus.s_tready  = (r_state == LOAD);
    assign bus.in_we     = w_beat;
    assign bus.in_waddr  = r_count;
    assign bus.in_raddr  = r_k;
    assign bus.w_en      = (r_state == MAC_ISSUE);
    assign bus.w_addr    = r_wbase + WAW'(r_k);
    assign bus.mac_start = (r_state == MAC_WAIT) && r_first;
    assign bus.acc_clear = (r_state == MAC_WAIT) && r_first && (r_k == '0);
    assign bus.b_addr    = r_n;
    assign bus.act_start = (r_state == ACT_WAIT) && r_first;
    assign bus.res_we    = (r_state == STORE);
    assign bus.res_addr  = RAW'(r_n);
    assign bus.busy      = (r_state != IDLE) && (r_state != DONE);
    assign bus.done      = (r_state == DONE);

`ifdef DENSE_SEQ_PERF_CNT_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else if ((r_state == IDLE) && bus.start) begin
            r_perf <= '0;
        end else if (bus.busy && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Self-checking bench for dense_layer_sequencer: scoreboard queues filled from a
// reference model of the address sequence, MAC/act responders with fixed latencies.
`timescale 1ns/1ps
module tb_dense_layer_sequencer;

    localparam int N_IN    = 64;
    localparam int N_OUT   = 10;
    localparam int MAC_LAT = 3;
    localparam int ACT_LAT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dense_layer_sequencer_if bus_if ();

`ifdef DENSE_SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    dense_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
`ifdef DENSE_SEQ_PERF_CNT_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit spur_en  = 1'b0;
    int md       = 0;
    int ad       = 0;

    int q_in[$];
    int q_w[$];
    int q_r[$];
    bit q_clr[$];
    int q_b[$];
    int q_res[$];

    // Responder: mac_done MAC_LAT cycles after mac_start, act_done ACT_LAT after act_start.
    // In spurious mode it also raises done inputs where they must be ignored.
    always @(negedge clk) begin
        bus_if.mac_done = 1'b0;
        bus_if.act_done = 1'b0;
        if (rst) begin
            md = 0;
            ad = 0;
        end else begin
            if (md > 0) begin
                md = md - 1;
                if (md == 0) bus_if.mac_done = 1'b1;
            end
            if (ad > 0) begin
                ad = ad - 1;
                if (ad == 0) bus_if.act_done = 1'b1;
                if (spur_en && ad == ACT_LAT - 1) bus_if.mac_done = 1'b1;
            end
            if (bus_if.mac_start) begin
                md = MAC_LAT;
                if (spur_en) begin
                    bus_if.mac_done = 1'b1;
                    bus_if.act_done = 1'b1;
                end
            end
            if (bus_if.act_start) begin
                ad = ACT_LAT;
                if (spur_en) bus_if.act_done = 1'b1;
            end
        end
    end

    task automatic test_reset();
        logic [8:0]  flags;
        logic [35:0] addrs;
        rst = 1'b1;
        bus_if.start = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        flags = {bus_if.s_tready, bus_if.in_we, bus_if.w_en, bus_if.acc_clear, bus_if.mac_start,
                 bus_if.act_start, bus_if.res_we, bus_if.busy, bus_if.done};
        addrs = {bus_if.in_waddr, bus_if.in_raddr, bus_if.w_addr, bus_if.b_addr, bus_if.res_addr};
        n_checks++;
        if (flags !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000000 (start held with rst)", flags);
        end
        n_checks++;
        if (addrs !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_addrs: got %h expected 0", addrs);
        end
`ifdef DENSE_SEQ_PERF_CNT_EN
        n_checks++;
        if (perf_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_perf: got %0d expected 0", perf_cycles);
        end
`endif
        rst = 1'b0;
        bus_if.start = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy got %b expected 0", bus_if.busy);
        end
        $display("test_reset done");
    endtask

    // Starts a pass and streams N_IN beats; returns positioned in the MAC_ISSUE cycle.
    task automatic test_load(input bit toggle);
        int beats = 0;
        int cyc   = 0;
        int exp_a;
        q_in.delete();
        bus_if.start = 1'b1;
        @(negedge clk);
        #1;
        bus_if.start = 1'b0;
        while (beats < N_IN && cyc < 400) begin
            bus_if.s_tvalid = toggle ? (cyc % 2 == 0) : 1'b1;
            if (bus_if.s_tvalid) q_in.push_back(beats);
            #1;
            n_checks++;
            if (bus_if.s_tready !== 1'b1 || bus_if.in_we !== bus_if.s_tvalid) begin
                n_fail++;
                $display("FAIL load_hs: cyc %0d tready %b in_we %b expected 1 and %b",
                         cyc, bus_if.s_tready, bus_if.in_we, bus_if.s_tvalid);
            end
            if (bus_if.in_we === 1'b1 && q_in.size() > 0) begin
                exp_a = q_in.pop_front();
                n_checks++;
                if (bus_if.in_waddr !== exp_a[6:0]) begin
                    n_fail++;
                    $display("FAIL in_waddr: got %0d expected %0d", bus_if.in_waddr, exp_a);
                end
            end
            if (bus_if.s_tvalid) beats++;
            @(negedge clk);
            #1;
            cyc++;
        end
        bus_if.s_tvalid = 1'b0;
        #1;
        n_checks++;
        if (beats != N_IN || q_in.size() != 0) begin
            n_fail++;
            $display("FAIL load_count: beats %0d pending %0d expected %0d and 0", beats, q_in.size(), N_IN);
        end
        n_checks++;
        if (bus_if.s_tready !== 1'b0 || bus_if.w_en !== 1'b1) begin
            n_fail++;
            $display("FAIL load_end: tready %b w_en %b expected 0 and 1", bus_if.s_tready, bus_if.w_en);
        end
        $display("test_load toggle=%0d: %0d beats in %0d cycles", toggle, beats, cyc);
    endtask

    // Runs the compute phase to done, checking every issued address against the model.
    task automatic test_compute(input bit spur, input bit chk_perf);
        int cyc = 0, macs = 0, acts = 0, dones = 0, last_w = -1, step = -1, last_waddr = -1;
        int e;
        bit ec;
        q_w.delete(); q_r.delete(); q_clr.delete(); q_b.delete(); q_res.delete();
        for (int n = 0; n < N_OUT; n++) begin
            for (int k = 0; k < N_IN; k++) begin
                q_w.push_back(n * N_IN + k);
                q_r.push_back(k);
                q_clr.push_back(k == 0);
            end
            q_b.push_back(n);
            q_res.push_back(n);
        end
        spur_en = spur;
        while (dones == 0 && cyc < 8000) begin
            bus_if.start = 1'b0;
            if (bus_if.w_en === 1'b1) begin
                if (last_w >= 0 && step < 0) step = cyc - last_w;
                last_w = cyc;
                last_waddr = int'(bus_if.w_addr);
                n_checks++;
                if (q_w.size() == 0) begin
                    n_fail++;
                    $display("FAIL w_extra: got w_addr %0d expected no issue", bus_if.w_addr);
                end else begin
                    e = q_w.pop_front();
                    if (bus_if.w_addr !== e[9:0] || bus_if.in_raddr !== q_r[0][6:0]) begin
                        n_fail++;
                        $display("FAIL mac_addr: got w_addr %0d raddr %0d expected %0d %0d",
                                 bus_if.w_addr, bus_if.in_raddr, e, q_r[0]);
                    end
                    void'(q_r.pop_front());
                end
            end
            if (bus_if.mac_start === 1'b1) begin
                macs++;
                ec = (q_clr.size() > 0) ? q_clr.pop_front() : 1'b0;
                n_checks++;
                if (bus_if.acc_clear !== ec) begin
                    n_fail++;
                    $display("FAIL acc_clear: mac %0d got %b expected %b", macs, bus_if.acc_clear, ec);
                end
                if (spur && macs == 1) bus_if.start = 1'b1;
            end else begin
                n_checks++;
                if (bus_if.acc_clear !== 1'b0) begin
                    n_fail++;
                    $display("FAIL acc_clear_idle: got %b expected 0", bus_if.acc_clear);
                end
            end
            if (bus_if.act_start === 1'b1) begin
                acts++;
                e = (q_b.size() > 0) ? q_b.pop_front() : -1;
                n_checks++;
                if (int'(bus_if.b_addr) != e) begin
                    n_fail++;
                    $display("FAIL b_addr: got %0d expected %0d", bus_if.b_addr, e);
                end
            end
            if (bus_if.res_we === 1'b1) begin
                e = (q_res.size() > 0) ? q_res.pop_front() : -1;
                n_checks++;
                if (int'(bus_if.res_addr) != e) begin
                    n_fail++;
                    $display("FAIL res_addr: got %0d expected %0d", bus_if.res_addr, e);
                end
            end
            if (bus_if.done === 1'b1) begin
                dones++;
`ifdef DENSE_SEQ_PERF_CNT_EN
                // LOAD 64 + 640 MAC steps of 5 + per neuron ACT_ISSUE 1, ACT_WAIT 6, STORE 1
                if (chk_perf) begin
                    n_checks++;
                    if (perf_cycles !== 32'(N_IN + N_IN * N_OUT * (MAC_LAT + 2) + N_OUT * (1 + ACT_LAT + 1 + 1))) begin
                        n_fail++;
                        $display("FAIL perf_cycles: got %0d expected %0d", perf_cycles,
                                 N_IN + N_IN * N_OUT * (MAC_LAT + 2) + N_OUT * (1 + ACT_LAT + 1 + 1));
                    end
                end
`endif
            end
            @(negedge clk);
            #1;
            cyc++;
        end
        bus_if.start = 1'b0;
        spur_en = 1'b0;
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL done_seen: got %0d done pulses within %0d cycles expected 1", dones, cyc);
        end
        n_checks++;
        if (macs != N_IN * N_OUT || acts != N_OUT) begin
            n_fail++;
            $display("FAIL op_counts: mac_start %0d act_start %0d expected %0d %0d", macs, acts, N_IN * N_OUT, N_OUT);
        end
        n_checks++;
        if (q_w.size() + q_clr.size() + q_b.size() + q_res.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: got %0d pending entries expected 0",
                     q_w.size() + q_clr.size() + q_b.size() + q_res.size());
        end
        n_checks++;
        if (step != MAC_LAT + 2 || last_waddr != N_IN * N_OUT - 1) begin
            n_fail++;
            $display("FAIL mac_timing: step %0d last w_addr %0d expected %0d %0d",
                     step, last_waddr, MAC_LAT + 2, N_IN * N_OUT - 1);
        end
        n_checks++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: busy %b done %b expected 0 0", bus_if.busy, bus_if.done);
        end
        $display("test_compute spur=%0d: %0d mac, %0d act, %0d done in %0d cycles", spur, macs, acts, dones, cyc);
    endtask

    task automatic test_back_to_back();
        test_load(1'b0);
        test_compute(1'b0, 1'b1);
    endtask

    task automatic test_toggle_spurious();
        test_load(1'b1);
        test_compute(1'b1, 1'b0);
    endtask

    task automatic test_midrun_reset();
        int  cyc = 0;
        bit  hit = 1'b0;
        logic [8:0] flags;
        test_load(1'b0);
        while (!hit && cyc < 3000) begin
            if (bus_if.w_en === 1'b1 && int'(bus_if.w_addr) == 4 * N_IN + 17) begin
                hit = 1'b1;
            end else begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reach_n4_k17: got no issue of w_addr %0d in %0d cycles expected one", 4 * N_IN + 17, cyc);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        flags = {bus_if.s_tready, bus_if.in_we, bus_if.w_en, bus_if.acc_clear, bus_if.mac_start,
                 bus_if.act_start, bus_if.res_we, bus_if.busy, bus_if.done};
        n_checks++;
        if (flags !== 9'd0 || bus_if.w_addr !== 10'd0 || bus_if.in_raddr !== 7'd0 || bus_if.b_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: flags %b w_addr %0d raddr %0d b_addr %0d expected all 0",
                     flags, bus_if.w_addr, bus_if.in_raddr, bus_if.b_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("test_midrun_reset: reset applied after %0d cycles, restarting", cyc);
        test_load(1'b0);
        test_compute(1'b0, 1'b1);
    endtask

    initial begin
        bus_if.start    = 1'b0;
        bus_if.s_tvalid = 1'b0;
        test_reset();
        test_back_to_back();
        test_toggle_spurious();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
